booth_multiplier_seq: RTL and testbench

//  Sequential radix-2 Booth multiplier for the ALU datapath: one Booth step per clock.

---
 rtl/booth_multiplier_seq.sv | 81 ++++++++
 tb/tb_booth_multiplier_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential radix-2 Booth multiplier, one Booth step per clock
// Ports: clk (rising edge), rst_n (async active-low), en (start, sampled in IDLE),
//        A/B (WIDTH-bit operands), Output (registered 2*WIDTH product, held between ops),
//        busy (operation in RUN or DONE), done (one-cycle pulse when Output updates)
// Define BOOTH_MULT_UNSIGNED_EN for unsigned operands: WIDTH+1 steps, latency WIDTH+2.
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Output,
  output logic               busy,
  output logic               done
);
`ifdef BOOTH_MULT_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int CW = $clog2(QW + 1);
  localparam int HW = 2 * WIDTH - QW;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_next;
  logic [WIDTH:0] m, acc, sum, m_init;
  logic [QW-1:0] q, q_init;
  logic q_1;
  logic [CW-1:0] count;
`ifdef BOOTH_MULT_UNSIGNED_EN
  assign m_init = {1'b0, A};
  assign q_init = {1'b0, B};
`else
  assign m_init = {A[WIDTH-1], A};
  assign q_init = B;
`endif
  // Booth recoding of {Q[0],Q-1}: 01 adds M, 10 subtracts M, otherwise pass
  always_comb begin
    sum = ({q[0], q_1} == 2'b01) ? acc + m : ({q[0], q_1} == 2'b10) ? acc - m : acc;
  end
  always_comb begin
    state_next = state;
    busy = 1'b0;
    state_next = (state == S_IDLE) ? (en ? S_RUN : S_IDLE) :
                 (state == S_RUN) ? ((count == CW'(1)) ? S_DONE : S_RUN) : S_IDLE;
    busy = (state != S_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      acc <= '0;
      q <= '0;
      q_1 <= 1'b0;
      count <= '0;
      Output <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_IDLE && en) begin
        m <= m_init;
        q <= q_init;
        acc <= '0;
        q_1 <= 1'b0;
        count <= CW'(QW);
      end
      // arithmetic right shift of {Acc,Q,Q-1} after the add/subtract
      if (state == S_RUN) begin
        acc <= {sum[WIDTH], sum[WIDTH:1]};
        q <= {sum[0], q[QW-1:1]};
        q_1 <= q[0];
        count <= count - CW'(1);
      end
      if (state == S_DONE) Output <= {acc[HW-1:0], q};
    end
  end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: scoreboard bench for booth_multiplier_seq
module tb_booth_multiplier_seq;
  localparam int W = 8;
`ifdef BOOTH_MULT_UNSIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  logic clk, rst_n, en;
  logic [W-1:0] A, B;
  logic [2*W-1:0] Output;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last;

  booth_multiplier_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B),
    .Output(Output), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ae, be;
`ifdef BOOTH_MULT_UNSIGNED_EN
    ae = {{W{1'b0}}, a};
    be = {{W{1'b0}}, b};
`else
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
`endif
    return ae * be;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [2*W-1:0] got);
    @(negedge clk);
    A = a;
    B = b;
    en = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    en = 1'b0;
    lat = -1;
    got = 'x;
    for (int i = 1; i <= 4 * LAT; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        got = Output;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en = 1'b0;
    A = '0;
    B = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Output !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Output=%h busy=%b done=%b want 0000 0 0", Output, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (Output !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: Output=%h busy=%b done=%b want 0000 0 0", Output, busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6] = '{8'h10, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h80};
    logic [W-1:0] vb[6] = '{8'hFE, 8'h80, 8'h80, 8'h5A, 8'hFF, 8'h7F};
    int lat;
    logic [2*W-1:0] got, exp;
    for (int k = 0; k < 6; k++) begin
      run_op(va[k], vb[k], lat, got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL directed_%0d: A=%h B=%h Output=%h want %h", k, va[k], vb[k], got, exp);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL latency_%0d: got %0d want %0d", k, lat, LAT);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done_%0d: got %b want 0", k, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b0 || Output !== exp) begin
        errors++;
        $display("FAIL hold_%0d: done=%b Output=%h want 0 %h", k, done, Output, exp);
      end
      last = exp;
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b;
    logic [2*W-1:0] got, exp;
    for (int k = 0; k < 16; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b, lat, got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp || lat !== LAT) begin
        errors++;
        $display("FAIL random_%0d: A=%h B=%h Output=%h lat=%0d want %h lat=%0d", k, a, b, got, lat, exp, LAT);
      end
      last = exp;
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    logic [2*W-1:0] exp;
    @(negedge clk);
    A = 8'h85;
    B = 8'h3C;
    en = 1'b1;
    sb.push_back(model(8'h85, 8'h3C));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_start: got %b want 1", busy);
    end
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(negedge clk);
      if (i == 3) begin
        A = W'($urandom);
        B = W'($urandom);
        checks++;
        if (busy !== 1'b1 || Output !== last) begin
          errors++;
          $display("FAIL b2b_mid: busy=%b Output=%h want 1 %h", busy, Output, last);
        end
      end
      if (done) begin
        exp = sb.pop_front();
        checks++;
        if (Output !== exp) begin
          errors++;
          $display("FAIL b2b_result_%0d: Output=%h want %h", (first < 0) ? 1 : 2, Output, exp);
        end
        last = exp;
        if (first < 0) begin
          first = i;
          A = 8'h7B;
          B = 8'hF1;
          sb.push_back(model(8'h7B, 8'hF1));
        end else begin
          second = i;
          break;
        end
      end
    end
    en = 1'b0;
    checks++;
    if (first !== LAT || second !== 2 * LAT + 1) begin
      errors++;
      $display("FAIL b2b_timing: done at %0d,%0d want %0d,%0d", first, second, LAT, 2 * LAT + 1);
    end
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [2*W-1:0] got, exp;
    bit seen = 0;
    @(negedge clk);
    A = 8'h10;
    B = 8'hFE;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || Output !== last) begin
      errors++;
      $display("FAIL mid_no_partial: busy=%b Output=%h want 1 %h", busy, Output, last);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (Output !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: Output=%h busy=%b done=%b want 0000 0 0", Output, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (seen || busy !== 1'b0 || Output !== '0) begin
      errors++;
      $display("FAIL mid_abort: done_seen=%b busy=%b Output=%h want 0 0 0000", seen, busy, Output);
    end
    run_op(8'h7F, 8'h7F, lat, got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp || lat !== LAT) begin
      errors++;
      $display("FAIL mid_recover: Output=%h lat=%0d want %h lat=%0d", got, lat, exp, LAT);
    end
  endtask

  initial begin
    last = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
